// File: rtl/reg_access_ctrl_if.sv
// reg_access_ctrl_if: issue, operand, writeback and register-file signals of reg_access_ctrl
interface reg_access_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW = 5
);
  logic iss_valid;
  logic iss_ready;
  logic [AW-1:0] iss_rs1;
  logic [AW-1:0] iss_rs2;
  logic [AW-1:0] iss_rd;
  logic iss_rd_en;
  logic op_valid;
  logic op_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [AW-1:0] op_rd;
  logic wb_valid;
  logic [AW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0] rf_rs1;
  logic [AW-1:0] rf_rs2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic rf_we;
  logic [AW-1:0] rf_rd;
  logic [XLEN-1:0] rf_wdata;
  modport slave (
    input iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en, op_ready,
    input wb_valid, wb_rd, wb_data, rf_rdata1, rf_rdata2,
    output iss_ready, op_valid, op_a, op_b, op_rd,
    output rf_rs1, rf_rs2, rf_we, rf_rd, rf_wdata
  );
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en, op_ready,
    output wb_valid, wb_rd, wb_data, rf_rdata1, rf_rdata2,
    input iss_ready, op_valid, op_a, op_b, op_rd,
    input rf_rs1, rf_rs2, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: scoreboarded operand fetch with writeback bypass and registered operand handshake
module reg_access_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = 5
) (
  input logic clk,
  input logic rst_n,
  reg_access_ctrl_if.slave bus,
  output logic [AW:0] pend_cnt
);
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_next;
  logic [AW:0] cnt_next;
  logic hit1;
  logic hit2;
  logic hitd;
  logic raw;
  logic waw;
  logic accept;
  logic [XLEN-1:0] val_a;
  logic [XLEN-1:0] val_b;
  assign bus.rf_rs1 = bus.iss_rs1;
  assign bus.rf_rs2 = bus.iss_rs2;
  assign bus.rf_rd = bus.wb_rd;
  assign bus.rf_wdata = bus.wb_data;
  assign bus.rf_we = rst_n && bus.wb_valid && bus.wb_rd != '0;
  // operand bypass and hazard detection; a same-cycle writeback resolves the hazard it would clear
  always_comb begin
    hit1 = bus.wb_valid && bus.wb_rd == bus.iss_rs1;
    hit2 = bus.wb_valid && bus.wb_rd == bus.iss_rs2;
    hitd = bus.wb_valid && bus.wb_rd == bus.iss_rd;
    val_a = bus.iss_rs1 == '0 ? '0 : hit1 ? bus.wb_data : bus.rf_rdata1;
    val_b = bus.iss_rs2 == '0 ? '0 : hit2 ? bus.wb_data : bus.rf_rdata2;
    raw = (bus.iss_rs1 != '0 && pending[bus.iss_rs1] && !hit1) ||
          (bus.iss_rs2 != '0 && pending[bus.iss_rs2] && !hit2);
    waw = bus.iss_rd_en && bus.iss_rd != '0 && pending[bus.iss_rd] && !hitd;
    bus.iss_ready = rst_n && !raw && !waw && (!bus.op_valid || bus.op_ready);
    accept = bus.iss_valid && bus.iss_ready;
  end
  // next scoreboard: clear on writeback, then set on accept so a same-index set wins
  always_comb begin
    pend_next = pending;
    if (bus.wb_valid && bus.wb_rd != '0) pend_next[bus.wb_rd] = 1'b0;
    if (accept && bus.iss_rd_en && bus.iss_rd != '0) pend_next[bus.iss_rd] = 1'b1;
    cnt_next = '0;
    for (int i = 1; i < NREG; i++) cnt_next = cnt_next + (AW+1)'(pend_next[i]);
  end
  // scoreboard and its popcount
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      pend_cnt <= '0;
    end else begin
      pending <= pend_next;
      pend_cnt <= cnt_next;
    end
  end
  // operand bundle register: load on accept, drop when consumed, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.op_valid <= 1'b0;
      bus.op_a <= '0;
      bus.op_b <= '0;
      bus.op_rd <= '0;
    end else if (accept) begin
      bus.op_valid <= 1'b1;
      bus.op_a <= val_a;
      bus.op_b <= val_b;
      bus.op_rd <= bus.iss_rd_en ? bus.iss_rd : '0;
    end else if (bus.op_ready) begin
      bus.op_valid <= 1'b0;
    end
  end
endmodule
